// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction fetch path.
//   fetch_state_t : fetch FSM states
//   NOP_ENC       : encoding of the no-op instruction, used as the reset value of instr
//   reuse_entry_t : one-entry reuse buffer payload {addr, instr, valid}
package cpu_pkg;

   localparam int unsigned CPU_ADDR_W = 32;
   localparam int unsigned CPU_DATA_W = 32;

   localparam logic [CPU_DATA_W-1:0] NOP_ENC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [CPU_ADDR_W-1:0] addr;
      logic [CPU_DATA_W-1:0] instr;
      logic                  v;
   } reuse_entry_t;

endpackage

// File: rtl/reg_multi_bit.sv
// Multi-bit register with write enable and asynchronous active-low reset.
//   clk, rst_n : clock, async active-low reset (q returns to RST_VAL)
//   we         : write enable, q loads d on the next rising edge
//   d / q      : data in / registered data out
module reg_multi_bit
   import cpu_pkg::*;
#(
   parameter int unsigned     W       = 32,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] val_q;
   logic [W-1:0] val_d;

   // Hold unless written.
   always_comb begin
      val_d = val_q;
      if (we) begin
         val_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= RST_VAL;
      end else begin
         val_q <= val_d;
      end
   end

   assign q = val_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one request/grant/response fetch per PC value
// and releases the PC (stallPC=0) for exactly one cycle per delivered instruction.
// Optional feature macro: FETCH_REUSE_EN (one-entry reuse buffer that skips
// memory when the PC repeats the last delivered address).
//   clk, rst         : clock, async active-low reset
//   halt             : no new fetch is started from IDLE while high
//   flush            : branch redirect, drops the in-flight fetch
//   currAddr         : current PC value
//   stallPC          : 1 = PC holds; 0 only while instrValid=1
//   instr/instrValid : registered instruction and its 1-cycle valid pulse
//   mem_req/mem_addr : registered fetch request and address
//   mem_gnt          : request accepted (used in ISSUE only)
//   mem_rvalid/rdata : read response (used in WAIT only)
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 32,
   parameter int unsigned         DATA_W    = 32,
   parameter logic [DATA_W-1:0]   NOP_INSTR = DATA_W'(NOP_ENC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              flush,
   input  logic [ADDR_W-1:0] currAddr,
   output logic              stallPC,
   output logic [DATA_W-1:0] instr,
   output logic              instrValid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   fetch_state_t      state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              discard_q, discard_d;

   logic              instr_we_c;
   logic [DATA_W-1:0] instr_wd_c;
   logic              reuse_hit_c;
   logic [DATA_W-1:0] reuse_instr_c;

`ifdef FETCH_REUSE_EN
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [DATA_W-1:0] last_instr_q, last_instr_d;
   logic              last_v_q, last_v_d;

   assign reuse_hit_c   = last_v_q && (currAddr == last_addr_q);
   assign reuse_instr_c = last_instr_q;

   // Refill on every memory delivery; any flush invalidates the entry.
   always_comb begin
      last_addr_d  = last_addr_q;
      last_instr_d = last_instr_q;
      last_v_d     = last_v_q;
      if ((state_q == WAIT) && instr_we_c) begin
         last_addr_d  = mem_addr_q;
         last_instr_d = mem_rdata;
         last_v_d     = 1'b1;
      end
      if (flush) begin
         last_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_addr_q  <= '0;
         last_instr_q <= NOP_INSTR;
         last_v_q     <= 1'b0;
      end else begin
         last_addr_q  <= last_addr_d;
         last_instr_q <= last_instr_d;
         last_v_q     <= last_v_d;
      end
   end
`else
   assign reuse_hit_c   = 1'b0;
   assign reuse_instr_c = '0;
`endif

   // Next-state, request and discard control.
   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      discard_d  = discard_q;
      instr_we_c = 1'b0;
      instr_wd_c = mem_rdata;

      case (state_q)
         IDLE: begin
            if (!halt) begin
               if (reuse_hit_c) begin
                  instr_we_c = 1'b1;
                  instr_wd_c = reuse_instr_c;
                  state_d    = DONE;
               end else begin
                  mem_addr_d = currAddr;
                  mem_req_d  = 1'b1;
                  state_d    = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            // Request stays up until granted; no withdrawal.
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               // A flush arriving with the data also kills it.
               if (discard_q || flush) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  instr_we_c = 1'b1;
                  state_d    = DONE;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      instr_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_valid_q <= 1'b0;
         discard_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_valid_q <= instr_valid_d;
         discard_q     <= discard_d;
      end
   end

   reg_multi_bit #(
      .W       (DATA_W),
      .RST_VAL (NOP_INSTR)
   ) u_instr_reg (
      .clk   (clk),
      .rst_n (rst),
      .we    (instr_we_c),
      .d     (instr_wd_c),
      .q     (instr)
   );

   assign stallPC    = ~(state_q == DONE);
   assign instrValid = instr_valid_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A transaction-level model plays the
// PC and the memory: each fetch is described by address, grant delay, response
// delay, data and an optional flush point, and the expected cycle-by-cycle
// outcome follows from those alone.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        flush;
   logic [31:0] currAddr;
   logic        stallPC;
   logic [31:0] instr;
   logic        instrValid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_instr;

   instr_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .halt       (halt),
      .flush      (flush),
      .currAddr   (currAddr),
      .stallPC    (stallPC),
      .instr      (instr),
      .instrValid (instrValid),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Record one check result.
   task automatic chk(input string tag, input bit ok,
                      input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (!ok) begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One fetch starting from IDLE at a falling edge. fl_at selects the fetch
   // cycle carrying flush (0..gd in ISSUE, gd+1..gd+1+rd in WAIT), -1 = none.
   task automatic fetch(input logic [31:0] addr, input int gd, input int rd,
                        input logic [31:0] data, input int fl_at);
      bit dropped;
      dropped    = (fl_at >= 0);
      currAddr   = addr;
      halt       = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      tick();
      for (int k = 0; k <= gd; k++) begin
         chk("issue_req", mem_req === 1'b1, 32'(mem_req), 32'd1);
         chk("issue_addr", mem_addr === addr, mem_addr, addr);
         chk("issue_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
         chk("issue_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         mem_gnt    = (k == gd);
         mem_rvalid = 1'(($urandom % 2));
         mem_rdata  = $urandom;
         flush      = (fl_at == k);
         currAddr   = $urandom;
         tick();
      end
      mem_gnt = 1'b0;
      flush   = 1'b0;
      for (int j = 0; j <= rd; j++) begin
         chk("wait_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
         chk("wait_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
         chk("wait_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         mem_gnt    = 1'(($urandom % 2));
         mem_rvalid = (j == rd);
         mem_rdata  = (j == rd) ? data : $urandom;
         flush      = (fl_at == gd + 1 + j);
         tick();
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      if (dropped) begin
         chk("drop_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         chk("drop_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
         chk("drop_instr", instr === exp_instr, instr, exp_instr);
      end else begin
         exp_instr = data;
         chk("done_valid", instrValid === 1'b1, 32'(instrValid), 32'd1);
         chk("done_stall", stallPC === 1'b0, 32'(stallPC), 32'd0);
         chk("done_instr", instr === data, instr, data);
         tick();
         chk("after_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         chk("after_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
      end
      chk("end_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
   endtask

   initial begin
      logic [31:0] pc;
      int          gd;
      int          rd;
      int          fl;

      rst        = 1'b0;
      halt       = 1'b1;
      flush      = 1'b0;
      currAddr   = 32'h0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      exp_instr  = NOP;

      // Reset state.
      #12;
      chk("rst_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr === 32'h0, mem_addr, 32'h0);
      chk("rst_instr", instr === NOP, instr, NOP);
      chk("rst_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
      chk("rst_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Halt in IDLE for 10 cycles: nothing happens.
      currAddr = 32'h0000_0080;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("halt_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
         chk("halt_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
      end

      // Basic fetch, minimum latency.
      fetch(32'h0000_0100, 0, 0, 32'hDEAD_BEEF, -1);

      // Grant backpressure for 5 cycles.
      fetch(32'h0000_0104, 5, 1, 32'h1234_5678, -1);

      // Flush in WAIT before the response; redirect to 0x300.
      fetch(32'h0000_0200, 0, 2, 32'hBAD0_BAD0, 1);
      fetch(32'h0000_0300, 1, 0, 32'h0300_0300, -1);

      // Flush together with rvalid, and flush in ISSUE.
      fetch(32'h0000_0340, 1, 1, 32'h5555_AAAA, 3);
      fetch(32'h0000_0380, 2, 1, 32'hAAAA_5555, 0);
      fetch(32'h0000_03C0, 0, 0, 32'h0BAD_F00D, -1);

      // Halt raised in ISSUE: fetch completes, then no new request.
      currAddr = 32'h0000_0600;
      halt     = 1'b0;
      tick();
      chk("hiss_req", mem_req === 1'b1, 32'(mem_req), 32'd1);
      halt    = 1'b1;
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      exp_instr  = 32'hCAFE_F00D;
      chk("hiss_valid", instrValid === 1'b1, 32'(instrValid), 32'd1);
      chk("hiss_instr", instr === exp_instr, instr, exp_instr);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hiss_idle_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
         chk("hiss_idle_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         chk("hiss_idle_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
      end

      // Randomized PC stream with random delays, data and flushes.
      pc = 32'h0000_1000;
      for (int t = 0; t < 40; t++) begin
         gd = int'($urandom_range(0, 3));
         rd = int'($urandom_range(0, 3));
         fl = (($urandom % 4) == 0) ? int'($urandom_range(0, gd + rd + 1)) : -1;
         fetch(pc, gd, rd, $urandom, fl);
         pc = (fl >= 0) ? {$urandom, 2'b00} + 32'h0001_0000 : pc + 32'd4;
      end

`ifdef FETCH_REUSE_EN
      // Same PC twice: the second delivery bypasses memory.
      fetch(32'h0000_0400, 0, 0, 32'h4040_4040, -1);
      currAddr = 32'h0000_0400;
      halt     = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      chk("reuse_valid", instrValid === 1'b1, 32'(instrValid), 32'd1);
      chk("reuse_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
      chk("reuse_instr", instr === 32'h4040_4040, instr, 32'h4040_4040);
      tick();
      chk("reuse_after_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
      // After a flush the entry is gone and memory is used again.
      halt  = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      fetch(32'h0000_0400, 0, 0, 32'h4141_4141, -1);
`endif

      // Async reset asserted in WAIT.
      fetch(32'h0000_0700, 0, 0, 32'h7070_7070, -1);
      currAddr = 32'h0000_0800;
      halt     = 1'b0;
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      halt    = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
      chk("arst_instr", instr === NOP, instr, NOP);
      chk("arst_stall", stallPC === 1'b1, 32'(stallPC), 32'd1);
      chk("arst_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
      @(negedge clk);
      rst        = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5A5A_5A5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stale_valid", instrValid === 1'b0, 32'(instrValid), 32'd0);
         chk("stale_instr", instr === NOP, instr, NOP);
         chk("stale_req", mem_req === 1'b0, 32'(mem_req), 32'd0);
      end
      mem_rvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
